// File: rtl/psm_pkg.sv
// rtl/psm_pkg.sv - shared state type, width helpers and leading-one search
// for pseudo_softmax_stream.
package psm_pkg;

  typedef enum logic [1:0] {LOAD, NORM, RECIP, EMIT} psm_state_t;

  function automatic int sum_width(input int in_w, input int depth);
    return (2 ** in_w) + $clog2(depth);
  endfunction

  function automatic int exp_width(input int sum_w);
    return $clog2(sum_w + 1);
  endfunction

  // Index of the most significant set bit; 0 for an all-zero input.
  function automatic logic [6:0] lead_one(input logic [63:0] v);
    logic [6:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = 7'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/psm_reciprocal.sv
// rtl/psm_reciprocal.sv - combinational M -> (R, d) reciprocal-mantissa table
// for 1/(1.M), elaborated from the closed-form quotient.
module psm_reciprocal #(
  parameter int MANT_W = 3
) (
  input  logic [MANT_W-1:0] m_i,
  output logic [MANT_W-1:0] r_o,
  output logic              d_o
);

  logic [MANT_W-1:0] tbl [2**MANT_W];

  for (genvar g = 0; g < 2**MANT_W; g++) begin : g_tbl
    localparam int Q = (2 ** (2 * MANT_W + 1)) / ((2 ** MANT_W) + g) - (2 ** MANT_W);
    if (g == 0) begin : g_one
      // 1/1.0 is exactly 1.0, so no exponent bump and a zero mantissa.
      assign tbl[g] = '0;
    end else begin : g_frac
      assign tbl[g] = MANT_W'(Q);
    end
  end

  assign r_o = tbl[m_i];
  assign d_o = |m_i;

endmodule

// File: rtl/pseudo_softmax_stream.sv
// rtl/pseudo_softmax_stream.sv - streaming log2-domain pseudo-softmax engine.
// Optional PSM_ARGMAX_EN adds out_is_max flagging the first maximum element.
module pseudo_softmax_stream
  import psm_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int DEPTH  = 8,
  parameter int MANT_W = 3,
  localparam int SUM_W = sum_width(IN_W, DEPTH),
  localparam int EXP_W = exp_width(SUM_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_last
`ifdef PSM_ARGMAX_EN
  ,
  output logic              out_is_max
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  psm_state_t        state_q, state_d;
  logic [SUM_W-1:0]  acc_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     k_q;
  logic [IN_W-1:0]   buf_q [DEPTH];
  logic [EXP_W-1:0]  e_q;
  logic [MANT_W-1:0] m_q, r_q;
  logic              d_q;

  logic              in_hs, out_hs, closing, emit_last;
  logic [6:0]        lead;
  logic [MANT_W-1:0] m_next, rec_r;
  logic              rec_d;

  assign in_ready  = (state_q == LOAD) && !rst;
  assign in_hs     = in_valid && in_ready;
  assign closing   = in_hs && (in_last || (cnt_q == CW'(DEPTH - 1)));
  assign out_hs    = out_valid && out_ready;
  assign emit_last = (CW'(k_q) == (cnt_q - CW'(1)));

  // Mantissa = bits just below the leading one, zero-filled when E < MANT_W.
  assign lead   = lead_one(64'(acc_q));
  assign m_next = MANT_W'({acc_q, {MANT_W{1'b0}}} >> lead);

  psm_reciprocal #(.MANT_W(MANT_W)) u_recip (
    .m_i (m_q),
    .r_o (rec_r),
    .d_o (rec_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    case (state_q)
      LOAD:    if (closing) state_d = NORM;
      NORM:    state_d = RECIP;
      RECIP:   state_d = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && emit_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      k_q   <= '0;
      e_q   <= '0;
      m_q   <= '0;
      r_q   <= '0;
      d_q   <= 1'b0;
    end else begin
      if (in_hs) begin
        buf_q[cnt_q[IW-1:0]] <= in_data;
        acc_q <= acc_q + (SUM_W'(1) << in_data);
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == NORM) begin
        e_q <= EXP_W'(lead);
        m_q <= m_next;
      end
      if (state_q == RECIP) begin
        r_q <= rec_r;
        d_q <= rec_d;
      end
      if (out_hs) begin
        if (emit_last) begin
          acc_q <= '0;
          cnt_q <= '0;
          k_q   <= '0;
        end else begin
          k_q <= k_q + IW'(1);
        end
      end
    end
  end

  // buf[k] <= E always holds, so the subtraction cannot wrap.
  assign out_exp  = out_valid ? (e_q - EXP_W'(buf_q[k_q]) + EXP_W'(d_q)) : '0;
  assign out_mant = out_valid ? r_q : '0;
  assign out_last = out_valid && emit_last;

`ifdef PSM_ARGMAX_EN
  logic [IN_W-1:0] max_q;
  logic [IW-1:0]   max_idx_q;

  // Strict compare keeps the index of the first occurrence of the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q     <= '0;
      max_idx_q <= '0;
    end else if (in_hs && ((cnt_q == '0) || (in_data > max_q))) begin
      max_q     <= in_data;
      max_idx_q <= cnt_q[IW-1:0];
    end
  end

  assign out_is_max = out_valid && (k_q == max_idx_q);
`endif

endmodule

// File: tb/tb_pseudo_softmax_stream.sv
// tb/tb_pseudo_softmax_stream.sv - directed self-checking bench for
// pseudo_softmax_stream (default IN_W=3, DEPTH=8, MANT_W=3).
module tb_pseudo_softmax_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_exp;
  logic [2:0] out_mant;
  logic       out_last;
`ifdef PSM_ARGMAX_EN
  logic       out_is_max;
`endif

  int nchecks = 0;
  int nerrors = 0;
  int vec_q[$];
  int exp_q[$];

  pseudo_softmax_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_last  (out_last)
`ifdef PSM_ARGMAX_EN
    ,
    .out_is_max(out_is_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv)
    else begin
      nerrors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Called just after a negedge; sends vec_q one beat per cycle.
  task automatic send_vec(input bit use_last);
    for (int i = 0; i < vec_q.size(); i++) begin
      chk("in_ready_load", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 3'(vec_q[i]);
      in_last  = use_last && (i == vec_q.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // NORM and RECIP show no output; out_valid rises on the third cycle.
  task automatic check_latency();
    chk("norm_valid", 32'(out_valid), 32'd0);
    chk("norm_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("recip_valid", 32'(out_valid), 32'd0);
    chk("recip_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("emit_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic recv(input int mant, input int max_idx);
    out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk("beat_exp", 32'(out_exp), 32'(exp_q[i]));
      chk("beat_mant", 32'(out_mant), 32'(mant));
      chk("beat_last", 32'(out_last), 32'(i == exp_q.size() - 1));
`ifdef PSM_ARGMAX_EN
      chk("beat_is_max", 32'(out_is_max), 32'(i == max_idx));
`endif
      @(negedge clk);
    end
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_out_mant", 32'(out_mant), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
`ifdef PSM_ARGMAX_EN
    chk("rst_is_max", 32'(out_is_max), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Eight zeros, in_last on 8th: S=8, E=3, M=0
    vec_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_vec(1'b1);
    check_latency();
    exp_q = '{3, 3, 3, 3, 3, 3, 3, 3};
    recv(0, 0);

    // Single element x=5: 1.0
    vec_q = '{5};
    send_vec(1'b1);
    check_latency();
    exp_q = '{0};
    recv(0, 0);

    // {2,1,0}: S=7, E=2, M=6, R=1, d=1
    vec_q = '{2, 1, 0};
    send_vec(1'b1);
    check_latency();
    exp_q = '{1, 2, 3};
    recv(1, 0);

    // Eight ones without in_last: closes on DEPTH-th beat, S=16, E=4
    vec_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_vec(1'b0);
    check_latency();
    exp_q = '{3, 3, 3, 3, 3, 3, 3, 3};
    recv(0, 0);

    // Backpressure on the second beat of {2,1,0}
    vec_q = '{2, 1, 0};
    send_vec(1'b1);
    check_latency();
    chk("bp_exp0", 32'(out_exp), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_exp", 32'(out_exp), 32'd2);
      chk("bp_hold_mant", 32'(out_mant), 32'd1);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_exp1", 32'(out_exp), 32'd2);
    @(negedge clk);
    chk("bp_exp2", 32'(out_exp), 32'd3);
    chk("bp_last2", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_ready", 32'(in_ready), 32'd1);

    // Reset mid-EMIT, then {3,3}: S=16, E=4, exp=1 twice
    vec_q = '{2, 1, 0};
    send_vec(1'b1);
    check_latency();
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", 32'(out_valid), 32'd0);
    chk("after_rst_ready", 32'(in_ready), 32'd1);
    chk("after_rst_exp", 32'(out_exp), 32'd0);
    vec_q = '{3, 3};
    send_vec(1'b1);
    check_latency();
    exp_q = '{1, 1};
    recv(0, 0);

    // {1,7,7,3}: S=266, E=8, M=0; maximum first at index 1
    vec_q = '{1, 7, 7, 3};
    send_vec(1'b1);
    check_latency();
    exp_q = '{7, 1, 1, 5};
    recv(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
